// File: rtl/fire3_squeeze_ctrl.sv
// fire3 squeeze 1x1 conv sequencer: sweeps weight ROM per pixel,
// drives MAC enable/clear/last, waits out MAC latency, writes result.
module fire3_squeeze_ctrl #(
  parameter int ADDR    = 7,
  parameter int IN_CH   = 128,
  parameter int NUM_PIX = 3025,
  parameter int PIX_W   = 12,
  parameter int MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             act_valid,
  output logic             act_ready,
  output logic [ADDR-1:0]  rom_addr,
  output logic             mac_en,
  output logic             mac_clr,
  output logic             mac_last,
  output logic             wr_en,
  input  logic             wr_ready,
  output logic [PIX_W-1:0] pix_idx,
  output logic             busy,
  output logic             done
);

  localparam int LW = (MAC_LAT > 1) ? $clog2(MAC_LAT + 1) : 1;
  localparam logic [ADDR-1:0]  CH_LAST  = ADDR'(IN_CH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIX - 1);
  localparam logic [LW-1:0]    LAT_INIT = LW'(MAC_LAT);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  state_t state, state_n;

  logic [ADDR-1:0]  ch_cnt, ch_n;
  logic [PIX_W-1:0] pix_cnt, pix_n;
  logic [LW-1:0]    lat_cnt, lat_n;
  logic             beat, first_ch, last_ch;

  assign rom_addr = ch_cnt;
  assign pix_idx  = pix_cnt;
  assign first_ch = (ch_cnt == '0);
  assign last_ch  = (ch_cnt == CH_LAST);
  assign beat     = (state == RUN) && act_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ch_cnt  <= '0;
      pix_cnt <= '0;
      lat_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      ch_cnt  <= ch_n;
      pix_cnt <= pix_n;
      lat_cnt <= lat_n;
      busy    <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n   = state;
    ch_n      = ch_cnt;
    pix_n     = pix_cnt;
    lat_n     = lat_cnt;
    act_ready = 1'b0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    mac_last  = 1'b0;
    wr_en     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          ch_n    = '0;
          pix_n   = '0;
        end
      end
      RUN: begin
        act_ready = 1'b1;
        mac_en    = beat;
        mac_clr   = beat && first_ch;
        mac_last  = beat && last_ch;
        if (beat) begin
          if (last_ch) begin
            ch_n    = '0;
            lat_n   = LAT_INIT;
            state_n = (MAC_LAT == 0) ? WRITE : DRAIN;
          end else begin
            ch_n = ch_cnt + ADDR'(1);
          end
        end
      end
      DRAIN: begin
        // lat_cnt <= 1 also guards against a stale zero
        if (lat_cnt <= LW'(1)) begin
          lat_n   = '0;
          state_n = WRITE;
        end else begin
          lat_n = lat_cnt - LW'(1);
        end
      end
      WRITE: begin
        wr_en = 1'b1;
        if (wr_ready) begin
          if (pix_cnt == PIX_LAST) begin
            state_n = DONE;
          end else begin
            pix_n   = pix_cnt + PIX_W'(1);
            state_n = RUN;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        pix_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fire3_squeeze_ctrl.sv
// Bench for fire3_squeeze_ctrl: vector table, corner sequences,
// and randomized runs against a transaction-level scoreboard.
module tb_fire3_squeeze_ctrl;

  logic clk = 1'b0;
  logic rst, start_a, start_b, act_valid, wr_ready;

  logic       ardy_a, en_a, clr_a, last_a, wen_a, busy_a, done_a;
  logic [1:0] addr_a, pix_a;
  logic       ardy_b, en_b, clr_b, last_b, wen_b, busy_b, done_b;
  logic [2:0] addr_b, pix_b;

  int n_chk = 0;
  int n_fail = 0;
  int dcnt_a = 0;
  int dcnt_b = 0;

  always #5 clk = ~clk;

  fire3_squeeze_ctrl #(
    .ADDR(2), .IN_CH(4), .NUM_PIX(3), .PIX_W(2), .MAC_LAT(2)
  ) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .act_valid(act_valid), .act_ready(ardy_a),
    .rom_addr(addr_a), .mac_en(en_a), .mac_clr(clr_a),
    .mac_last(last_a), .wr_en(wen_a), .wr_ready(wr_ready),
    .pix_idx(pix_a), .busy(busy_a), .done(done_a)
  );

  fire3_squeeze_ctrl #(
    .ADDR(3), .IN_CH(8), .NUM_PIX(6), .PIX_W(3), .MAC_LAT(0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .act_valid(act_valid), .act_ready(ardy_b),
    .rom_addr(addr_b), .mac_en(en_b), .mac_clr(clr_b),
    .mac_last(last_b), .wr_en(wen_b), .wr_ready(wr_ready),
    .pix_idx(pix_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  function automatic int outs_a();
    return int'({ardy_a, addr_a, en_a, clr_a, last_a,
                 wen_a, pix_a, busy_a, done_a});
  endfunction

  function automatic int outs_b();
    return int'({ardy_b, addr_b, en_b, clr_b, last_b,
                 wen_b, pix_b, busy_b, done_b});
  endfunction

  // scoreboard view of whichever instance is selected
  logic sel = 1'b0;
  logic sb_on = 1'b0;
  logic m_ardy, m_en, m_clr, m_last, m_wr, m_done;
  int   m_addr, m_pix;
  int   m_in_ch, m_npix, m_lat;
  int   sb_k, sb_beats, sb_wrs, sb_dones, sb_cyc, sb_exp_wr;
  bit   sb_prev_wr;

  always_comb begin
    m_ardy = sel ? ardy_b : ardy_a;
    m_en   = sel ? en_b : en_a;
    m_clr  = sel ? clr_b : clr_a;
    m_last = sel ? last_b : last_a;
    m_wr   = sel ? wen_b : wen_a;
    m_done = sel ? done_b : done_a;
    m_addr = sel ? int'(addr_b) : int'(addr_a);
    m_pix  = sel ? int'(pix_b) : int'(pix_a);
  end

  initial forever begin
    @(negedge clk);
    if (done_a) dcnt_a++;
    if (done_b) dcnt_b++;
    if (sb_on) begin
      chk("sb mac_en", int'(m_en), int'(act_valid & m_ardy));
      chk("sb addr range", int'(m_addr < m_in_ch), 1);
      if (m_en) begin
        chk("sb beat addr", m_addr, sb_k);
        chk("sb beat clr", int'(m_clr), int'(sb_k == 0));
        chk("sb beat last", int'(m_last), int'(sb_k == m_in_ch - 1));
        chk("sb beat pix", m_pix, sb_wrs);
        sb_beats++;
        sb_k++;
        if (sb_k == m_in_ch) begin
          sb_k = 0;
          sb_exp_wr = sb_cyc + m_lat + 1;
        end
      end
      if (m_wr && !sb_prev_wr) chk("sb write time", sb_cyc, sb_exp_wr);
      if (m_wr) begin
        chk("sb write pix", m_pix, sb_wrs);
        chk("sb write no ardy", int'(m_ardy), 0);
        if (wr_ready) sb_wrs++;
      end
      if (m_done) begin
        chk("sb done after writes", sb_wrs, m_npix);
        sb_dones++;
      end
      sb_prev_wr = m_wr;
      sb_cyc++;
    end
  end

  typedef struct {
    bit av;
    bit wr;
    int ardy, addr, en, clr, last, wen, pix, busy, done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int ardy, int addr, int en, int clr,
                              int last, int wen, int pix, int busy,
                              int done);
    vec_t v;
    v.av = 1'b1; v.wr = 1'b1;
    v.ardy = ardy; v.addr = addr; v.en = en; v.clr = clr;
    v.last = last; v.wen = wen; v.pix = pix; v.busy = busy;
    v.done = done;
    return v;
  endfunction

  task automatic pulse_start(input bit b);
    @(posedge clk); #1;
    if (b) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int n = 0;
    @(negedge clk);
    while ((busy_a || busy_b) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " idle reached"}, int'(n < lim), 1);
    @(posedge clk); #1;
  endtask

  task automatic run_random(input bit s);
    int n = 0;
    sel = s;
    m_in_ch = s ? 8 : 4;
    m_npix  = s ? 6 : 3;
    m_lat   = s ? 0 : 2;
    sb_k = 0; sb_beats = 0; sb_wrs = 0; sb_dones = 0;
    sb_cyc = 0; sb_exp_wr = -1; sb_prev_wr = 1'b0;
    act_valid = 1'b1;
    wr_ready = 1'b1;
    pulse_start(s);
    sb_on = 1'b1;
    while (sb_dones == 0 && n < 3000) begin
      @(posedge clk); #1;
      act_valid = ($urandom_range(0, 3) != 0);
      wr_ready  = ($urandom_range(0, 2) != 0);
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    sb_on = 1'b0;
    chk("rnd finished", int'(n < 3000), 1);
    chk("rnd beats", sb_beats, m_in_ch * m_npix);
    chk("rnd writes", sb_wrs, m_npix);
    chk("rnd dones", sb_dones, 1);
    chk("rnd busy low", int'(busy_a || busy_b), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nen, ea, d0;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    act_valid = 1'b0;
    wr_ready = 1'b0;

    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++)
        tbl.push_back(mk(1, k, 1, int'(k == 0), int'(k == 3), 0, p, 1, 0));
      for (int d = 0; d < 2; d++)
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, p, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, p, 1, 0));
    end
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    #3;
    chk("reset outs a", outs_a(), 0);
    chk("reset outs b", outs_b(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // basic run, one table row per cycle after start
    act_valid = 1'b1;
    wr_ready = 1'b1;
    pulse_start(1'b0);
    foreach (tbl[i]) begin
      act_valid = tbl[i].av;
      wr_ready = tbl[i].wr;
      @(negedge clk);
      chk($sformatf("row%0d act_ready", i), int'(ardy_a), tbl[i].ardy);
      chk($sformatf("row%0d rom_addr", i), int'(addr_a), tbl[i].addr);
      chk($sformatf("row%0d mac_en", i), int'(en_a), tbl[i].en);
      chk($sformatf("row%0d mac_clr", i), int'(clr_a), tbl[i].clr);
      chk($sformatf("row%0d mac_last", i), int'(last_a), tbl[i].last);
      chk($sformatf("row%0d wr_en", i), int'(wen_a), tbl[i].wen);
      chk($sformatf("row%0d pix_idx", i), int'(pix_a), tbl[i].pix);
      chk($sformatf("row%0d busy", i), int'(busy_a), tbl[i].busy);
      chk($sformatf("row%0d done", i), int'(done_a), tbl[i].done);
      @(posedge clk); #1;
    end

    // feeder stall on cycles 2..4 of pixel 0
    d0 = dcnt_a;
    act_valid = 1'b1;
    pulse_start(1'b0);
    nen = 0;
    for (int c = 0; c < 7; c++) begin
      act_valid = (c < 2 || c > 4);
      @(negedge clk);
      ea = (c < 2) ? c : ((c <= 4) ? 2 : c - 3);
      chk($sformatf("stall c%0d addr", c), int'(addr_a), ea);
      chk($sformatf("stall c%0d mac_en", c), int'(en_a), int'(act_valid));
      chk($sformatf("stall c%0d ardy", c), int'(ardy_a), 1);
      if (en_a) nen++;
      @(posedge clk); #1;
    end
    chk("stall beats pix0", nen, 4);
    act_valid = 1'b1;
    wait_idle("stall", 200);
    chk("stall done count", dcnt_a - d0, 1);

    // write backpressure on pixel 1
    d0 = dcnt_a;
    pulse_start(1'b0);
    n = 0;
    @(negedge clk);
    while (!(pix_a == 2'd1 && ardy_a) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp reach pix1", int'(pix_a == 2'd1 && ardy_a), 1);
    @(posedge clk); #1;
    wr_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!wen_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp wr_en seen", int'(wen_a), 1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp c%0d wr_en", i), int'(wen_a), 1);
      chk($sformatf("bp c%0d pix", i), int'(pix_a), 1);
      chk($sformatf("bp c%0d ardy", i), int'(ardy_a), 0);
      @(posedge clk); #1;
      if (i == 4) wr_ready = 1'b1;
      @(negedge clk);
    end
    chk("bp wr_en dropped", int'(wen_a), 0);
    chk("bp next pix", int'(pix_a), 2);
    chk("bp back in run", int'(ardy_a), 1);
    wait_idle("bp", 200);
    chk("bp done count", dcnt_a - d0, 1);

    // start ignored mid-run, then reset abort in DRAIN of pixel 1
    d0 = dcnt_a;
    pulse_start(1'b0);
    @(posedge clk); #1;
    start_a = 1'b1;
    @(negedge clk);
    chk("ign addr before", int'(addr_a), 1);
    @(posedge clk); #1;
    start_a = 1'b0;
    @(negedge clk);
    chk("ign addr after", int'(addr_a), 2);
    chk("ign pix", int'(pix_a), 0);
    n = 0;
    while (!(pix_a == 2'd1 && busy_a && !ardy_a && !wen_a) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort reach drain", int'(pix_a == 2'd1 && !ardy_a && !wen_a), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort outs", outs_a(), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort no done", dcnt_a - d0, 0);
    @(negedge clk);
    chk("abort idle busy", int'(busy_a), 0);
    pulse_start(1'b0);
    @(negedge clk);
    chk("restart pix", int'(pix_a), 0);
    chk("restart addr", int'(addr_a), 0);
    chk("restart clr", int'(clr_a), 1);
    wait_idle("restart", 200);
    chk("restart done count", dcnt_a - d0, 1);

    // zero MAC latency goes straight to WRITE
    d0 = dcnt_b;
    act_valid = 1'b1;
    wr_ready = 1'b1;
    pulse_start(1'b1);
    n = 0;
    @(negedge clk);
    while (!last_b && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("lat0 last seen", int'(last_b), 1);
    chk("lat0 last addr", int'(addr_b), 7);
    @(negedge clk);
    chk("lat0 wr next", int'(wen_b), 1);
    chk("lat0 ardy", int'(ardy_b), 0);
    chk("lat0 pix", int'(pix_b), 0);
    wait_idle("lat0", 400);
    chk("lat0 done count", dcnt_b - d0, 1);

    run_random(1'b0);
    run_random(1'b0);
    run_random(1'b1);
    run_random(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
